// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, MIPS opcode/funct
// values, instruction classes and the datapath select codes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_XOR  = 2'd2;
    localparam logic [1:0] ALU_SLT  = 2'd3;

    localparam logic [1:0] RD_RT    = 2'd0;
    localparam logic [1:0] RD_RD    = 2'd1;
    localparam logic [1:0] RD_RA    = 2'd2;

    localparam logic [1:0] WB_ALU   = 2'd0;
    localparam logic [1:0] WB_MEM   = 2'd1;
    localparam logic [1:0] WB_PC4   = 2'd2;

    typedef enum logic [3:0] {
        CL_ILL  = 4'd0,
        CL_J    = 4'd1,
        CL_JAL  = 4'd2,
        CL_JR   = 4'd3,
        CL_R    = 4'd4,
        CL_ADDI = 4'd5,
        CL_XORI = 4'd6,
        CL_LW   = 4'd7,
        CL_SW   = 4'd8,
        CL_BNE  = 4'd9
    } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: maps the latched instruction to a class code
// and the ALU function that class needs in EXEC and beyond.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output logic [3:0]  iclass,
    output logic [1:0]  alu_fn
);

    logic [5:0] op;
    logic [5:0] fn;

    assign op = ir[31:26];
    assign fn = ir[5:0];

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        iclass = CL_ILL;
        alu_fn = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_JR:  iclass = CL_JR;
                    FN_ADD: begin iclass = CL_R; alu_fn = ALU_ADD; end
                    FN_SUB: begin iclass = CL_R; alu_fn = ALU_SUB; end
                    FN_SLT: begin iclass = CL_R; alu_fn = ALU_SLT; end
                    default: ;
                endcase
            end
            OP_J:    iclass = CL_J;
            OP_JAL:  iclass = CL_JAL;
            OP_BNE:  begin iclass = CL_BNE;  alu_fn = ALU_SUB; end
            OP_ADDI: begin iclass = CL_ADDI; alu_fn = ALU_ADD; end
            OP_XORI: begin iclass = CL_XORI; alu_fn = ALU_XOR; end
            OP_LW:   begin iclass = CL_LW;   alu_fn = ALU_ADD; end
            OP_SW:   begin iclass = CL_SW;   alu_fn = ALU_ADD; end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle Moore control FSM: holds the instruction register and steps
// FETCH/DECODE/EXEC/MEM/WB, pulsing pc_we once in each instruction's last cycle.
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        zero,
    output logic [31:0] ir,
    output logic        pc_we,
    output logic        branch,
    output logic        jump,
    output logic        jr,
    output logic        reg_we,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wb_sel,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        mem_we,
    output logic [2:0]  state,
    output logic        illegal
);

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        illegal_q, illegal_d;
    logic [3:0]  iclass;
    logic [1:0]  alu_fn;
    logic        zero_unused;

    // The fetch stage consumes zero itself; a Moore controller must not look at it.
    assign zero_unused = zero;

    mc_decode u_decode (
        .ir     (ir_q),
        .iclass (iclass),
        .alu_fn (alu_fn)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            ir_q      <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_FETCH: begin
                ir_d    = instruction;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (iclass)
                    CL_J, CL_JAL, CL_JR: state_d = S_FETCH;
                    CL_ILL:              state_d = S_HALT;
                    default:             state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (iclass)
                    CL_BNE:       state_d = S_FETCH;
                    CL_LW, CL_SW: state_d = S_MEM;
                    default:      state_d = S_WB;
                endcase
            end
            S_MEM:   state_d = (iclass == CL_LW) ? S_WB : S_FETCH;
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        illegal_d = illegal_q | (state_d == S_HALT);
    end

    always_comb begin
        pc_we   = 1'b0;
        branch  = 1'b0;
        jump    = 1'b0;
        jr      = 1'b0;
        reg_we  = 1'b0;
        reg_dst = RD_RT;
        wb_sel  = WB_ALU;
        alu_src = 1'b0;
        alu_op  = ALU_ADD;
        mem_we  = 1'b0;

        // No ALU output register, so the ALU setup is held from EXEC to the terminal state.
        if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
            alu_op  = alu_fn;
            alu_src = iclass inside {CL_ADDI, CL_XORI, CL_LW, CL_SW};
        end

        case (state_q)
            S_DECODE: begin
                case (iclass)
                    CL_J: begin
                        pc_we = 1'b1;
                        jump  = 1'b1;
                    end
                    CL_JAL: begin
                        pc_we   = 1'b1;
                        jump    = 1'b1;
                        reg_we  = 1'b1;
                        reg_dst = RD_RA;
                        wb_sel  = WB_PC4;
                    end
                    CL_JR: begin
                        pc_we = 1'b1;
                        jump  = 1'b1;
                        jr    = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_EXEC: begin
                if (iclass == CL_BNE) begin
                    branch = 1'b1;
                    pc_we  = 1'b1;
                end
            end
            S_MEM: begin
                if (iclass == CL_SW) begin
                    mem_we = 1'b1;
                    pc_we  = 1'b1;
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                reg_dst = (iclass == CL_R)  ? RD_RD  : RD_RT;
                wb_sel  = (iclass == CL_LW) ? WB_MEM : WB_ALU;
            end
            default: ;
        endcase
    end

    assign ir      = ir_q;
    assign state   = state_q;
    assign illegal = illegal_q;

endmodule
